// File: rtl/spi_pwm_reg_peripheral.sv
// spi_pwm_reg_peripheral
//   Write-only SPI mode-0 target that loads the control-register bank of the
//   PWM output stage. SCLK/COPI/nCS arrive asynchronously. They are
//   synchronised to clk, and each 16-bit frame is deserialised MSB first.
//   A valid write frame commits its data byte to one of five registers.
//
//   Frame layout: [15] R/W (1 = write), [14:8] address, [7:0] data.
//
// Ports
//   clk          system clock (the only clock)
//   rst          synchronous active-high reset
//   sclk_in      SPI clock pin (asynchronous, idles low in mode 0)
//   copi_in      SPI data pin, controller to peripheral (asynchronous)
//   ncs_in       SPI chip select, active low (asynchronous)
//   en_out_7_0   reg 0x00
//   en_out_15_8  reg 0x01
//   en_pwm_7_0   reg 0x02
//   en_pwm_15_8  reg 0x03
//   pwm_duty     reg 0x04
//   wr_strobe    one-cycle pulse in the cycle a register is written
//   frame_err    one-cycle pulse when a frame has the wrong bit count
//   state_dbg    current frame FSM state (IDLE=0, SHIFT=1, COMMIT=2)
//
// Event semantics: wr_strobe and frame_err are single-cycle, mutually
// exclusive pulses. Each is raised in the COMMIT cycle that follows the
// synchronised rising edge of nCS. There is no back-pressure.
module spi_pwm_reg_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic [7:0] en_out_7_0,
  output logic [7:0] en_out_15_8,
  output logic [7:0] en_pwm_7_0,
  output logic [7:0] en_pwm_15_8,
  output logic [7:0] pwm_duty,
  output logic       wr_strobe,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;
  // Fills with ones after reset. Once the top bit is set, the ncs_sync and
  // ncs_d bits hold real pin samples rather than their reset values.
  logic [SYNC_STAGES:0]   fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_in};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_in};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;
  logic primed;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign primed    = fill[SYNC_STAGES];

  // ---------------------------------------------------------------------------
  // Frame FSM, deserialiser and register bank
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        armed;

  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        frame_write;

  assign frame_write = shift_reg[15];
  assign frame_addr  = shift_reg[14:8];
  assign frame_data  = shift_reg[7:0];
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      armed       <= 1'b0;
      en_out_7_0  <= '0;
      en_out_15_8 <= '0;
      en_pwm_7_0  <= '0;
      en_pwm_15_8 <= '0;
      pwm_duty    <= '0;
      wr_strobe   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;

      // nCS must be seen idle (high) before any frame is accepted. A frame
      // already running when reset is released is therefore ignored.
      if (primed && ncs_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ncs_fall && armed) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end

        SHIFT: begin
          // A bit clocked in together with the nCS rise is still captured.
          // COMMIT evaluates the count one cycle later.
          if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_cnt != 5'd17) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          if (ncs_rise) begin
            state <= COMMIT;
          end
        end

        COMMIT: begin
          state <= IDLE;
          if (bit_cnt != 5'd16) begin
            frame_err <= 1'b1;
          end else if (frame_write && (frame_addr <= MAX_ADDR)) begin
            wr_strobe <= 1'b1;
            case (frame_addr)
              7'h00:   en_out_7_0  <= frame_data;
              7'h01:   en_out_15_8 <= frame_data;
              7'h02:   en_pwm_7_0  <= frame_data;
              7'h03:   en_pwm_15_8 <= frame_data;
              7'h04:   pwm_duty    <= frame_data;
              default: ;
            endcase
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
